// File: rtl/isa_pkg.sv
// ISA constants for the 8-bit microprocessor: instruction field positions,
// opcode numbers, and the ALU function, branch-select and write-back encodings.
package isa_pkg;

    localparam int unsigned INSTR_W    = 17;
    localparam int unsigned OPCODE_MSB = 16;
    localparam int unsigned OPCODE_LSB = 12;
    localparam int unsigned DA_MSB     = 11;
    localparam int unsigned DA_LSB     = 9;
    localparam int unsigned AA_MSB     = 8;
    localparam int unsigned AA_LSB     = 6;
    localparam int unsigned BA_MSB     = 5;
    localparam int unsigned BA_LSB     = 3;
    localparam int unsigned OP_MSB     = 2;
    localparam int unsigned OP_LSB     = 0;

    typedef enum logic [4:0] {
        OPC_NOP  = 5'd0,
        OPC_MOV  = 5'd1,
        OPC_INC  = 5'd2,
        OPC_ADD  = 5'd3,
        OPC_SUB  = 5'd4,
        OPC_DEC  = 5'd5,
        OPC_AND  = 5'd6,
        OPC_OR   = 5'd7,
        OPC_XOR  = 5'd8,
        OPC_NOT  = 5'd9,
        OPC_MOVB = 5'd10,
        OPC_SHR  = 5'd11,
        OPC_SHL  = 5'd12,
        OPC_LDI  = 5'd13,
        OPC_ADI  = 5'd14,
        OPC_LD   = 5'd15,
        OPC_ST   = 5'd16,
        OPC_IN   = 5'd17,
        OPC_OUT  = 5'd18,
        OPC_BRZ  = 5'd19,
        OPC_JMP  = 5'd20
    } opcode_t;

    typedef enum logic [3:0] {
        FS_A     = 4'b0000,
        FS_INC   = 4'b0001,
        FS_ADD   = 4'b0010,
        FS_SUB   = 4'b0101,
        FS_DEC   = 4'b0110,
        FS_AND   = 4'b1000,
        FS_OR    = 4'b1001,
        FS_XOR   = 4'b1010,
        FS_NOT   = 4'b1011,
        FS_B     = 4'b1100,
        FS_SHR   = 4'b1101,
        FS_SHL   = 4'b1110
    } fs_t;

    typedef enum logic [1:0] {
        BS_NEXT = 2'b00,
        BS_COND = 2'b01,
        BS_JUMP = 2'b10,
        BS_RSVD = 2'b11
    } bs_t;

    typedef enum logic [1:0] {
        MD_ALU  = 2'b00,
        MD_MEM  = 2'b01,
        MD_PORT = 2'b10,
        MD_RSVD = 2'b11
    } md_t;

endpackage

// File: rtl/id_decode_logic.sv
// Combinational opcode-to-control map; unlisted and illegal opcodes yield
// an all-zero (NOP) control word.
module id_decode_logic
    import isa_pkg::*;
(
    input  logic [4:0] opcode,
    input  logic [2:0] op,
    output logic [1:0] bs,
    output logic       ps,
    output logic       mw,
    output logic       rw,
    output logic       ma,
    output logic       mb,
    output logic [1:0] md,
    output logic [3:0] fs,
    output logic [2:0] sh,
    output logic       cs,
    output logic       oe
);

    always_comb begin
        bs = BS_NEXT;
        ps = 1'b0;
        mw = 1'b0;
        rw = 1'b0;
        ma = 1'b0;
        mb = 1'b0;
        md = MD_ALU;
        fs = FS_A;
        sh = '0;
        cs = 1'b0;
        oe = 1'b0;

        case (opcode)
            OPC_MOV:  begin rw = 1'b1; fs = FS_A;   end
            OPC_INC:  begin rw = 1'b1; fs = FS_INC; end
            OPC_ADD:  begin rw = 1'b1; fs = FS_ADD; end
            OPC_SUB:  begin rw = 1'b1; fs = FS_SUB; end
            OPC_DEC:  begin rw = 1'b1; fs = FS_DEC; end
            OPC_AND:  begin rw = 1'b1; fs = FS_AND; end
            OPC_OR:   begin rw = 1'b1; fs = FS_OR;  end
            OPC_XOR:  begin rw = 1'b1; fs = FS_XOR; end
            OPC_NOT:  begin rw = 1'b1; fs = FS_NOT; end
            OPC_MOVB: begin rw = 1'b1; fs = FS_B;   end
            OPC_SHR:  begin rw = 1'b1; fs = FS_SHR; sh = op; end
            OPC_SHL:  begin rw = 1'b1; fs = FS_SHL; sh = op; end
            OPC_LDI:  begin rw = 1'b1; fs = FS_B;   mb = 1'b1; end
            OPC_ADI:  begin rw = 1'b1; fs = FS_ADD; mb = 1'b1; cs = 1'b1; end
            OPC_LD:   begin rw = 1'b1; md = MD_MEM;  end
            OPC_ST:   begin mw = 1'b1; end
            OPC_IN:   begin rw = 1'b1; md = MD_PORT; end
            OPC_OUT:  begin oe = 1'b1; end
            // Branch target PC + sign-extended OP is formed on the ALU adder.
            OPC_BRZ:  begin
                bs = BS_COND;
                ps = 1'b1;
                ma = 1'b1;
                mb = 1'b1;
                cs = 1'b1;
                fs = FS_ADD;
            end
            OPC_JMP:  begin bs = BS_JUMP; end
            default:  ;
        endcase
    end

endmodule

// File: rtl/instruction_decoder.sv
// Registered instruction decoder: register-address pass-through plus the
// decoded control word, captured each rising edge with synchronous reset.
module instruction_decoder
    import isa_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [16:0] Instruction_in,
    output logic [2:0]  DA,
    output logic [2:0]  AA,
    output logic [2:0]  BA,
    output logic [1:0]  BS,
    output logic        PS,
    output logic        MW,
    output logic        RW,
    output logic        MA,
    output logic        MB,
    output logic [1:0]  MD,
    output logic [3:0]  FS,
    output logic [2:0]  SH,
    output logic        CS,
    output logic        OE
);

    logic [1:0] bs_d;
    logic       ps_d;
    logic       mw_d;
    logic       rw_d;
    logic       ma_d;
    logic       mb_d;
    logic [1:0] md_d;
    logic [3:0] fs_d;
    logic [2:0] sh_d;
    logic       cs_d;
    logic       oe_d;

    id_decode_logic u_decode (
        .opcode (Instruction_in[OPCODE_MSB:OPCODE_LSB]),
        .op     (Instruction_in[OP_MSB:OP_LSB]),
        .bs     (bs_d),
        .ps     (ps_d),
        .mw     (mw_d),
        .rw     (rw_d),
        .ma     (ma_d),
        .mb     (mb_d),
        .md     (md_d),
        .fs     (fs_d),
        .sh     (sh_d),
        .cs     (cs_d),
        .oe     (oe_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            DA <= '0;
            AA <= '0;
            BA <= '0;
            BS <= '0;
            PS <= 1'b0;
            MW <= 1'b0;
            RW <= 1'b0;
            MA <= 1'b0;
            MB <= 1'b0;
            MD <= '0;
            FS <= '0;
            SH <= '0;
            CS <= 1'b0;
            OE <= 1'b0;
        end else begin
            DA <= Instruction_in[DA_MSB:DA_LSB];
            AA <= Instruction_in[AA_MSB:AA_LSB];
            BA <= Instruction_in[BA_MSB:BA_LSB];
            BS <= bs_d;
            PS <= ps_d;
            MW <= mw_d;
            RW <= rw_d;
            MA <= ma_d;
            MB <= mb_d;
            MD <= md_d;
            FS <= fs_d;
            SH <= sh_d;
            CS <= cs_d;
            OE <= oe_d;
        end
    end

endmodule

// File: tb/tb_instruction_decoder.sv
// Scoreboard bench for instruction_decoder: a table-driven reference model
// predicts each registered output word; a monitor compares one word per edge.
module tb_instruction_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [16:0] Instruction_in = '0;
    logic [2:0]  DA, AA, BA, SH;
    logic [1:0]  BS, MD;
    logic [3:0]  FS;
    logic        PS, MW, RW, MA, MB, CS, OE;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    logic        driving_done = 1'b0;

    typedef struct packed {
        logic [2:0] da, aa, ba;
        logic [1:0] bs;
        logic       ps, mw, rw, ma, mb;
        logic [1:0] md;
        logic [3:0] fs;
        logic [2:0] sh;
        logic       cs, oe;
    } ctrl_t;

    typedef struct {
        ctrl_t       exp;
        logic [16:0] instr;
        logic        rst;
    } item_t;

    item_t sb_q[$];

    instruction_decoder dut (
        .clk            (clk),
        .rst            (rst),
        .Instruction_in (Instruction_in),
        .DA             (DA),
        .AA             (AA),
        .BA             (BA),
        .BS             (BS),
        .PS             (PS),
        .MW             (MW),
        .RW             (RW),
        .MA             (MA),
        .MB             (MB),
        .MD             (MD),
        .FS             (FS),
        .SH             (SH),
        .CS             (CS),
        .OE             (OE)
    );

    always #5 clk = ~clk;

    // ALU function per opcode 0..20, straight from the ISA opcode table.
    function automatic logic [3:0] fs_of(int unsigned opc);
        logic [3:0] tab [0:20];
        tab = '{4'h0, 4'h0, 4'h1, 4'h2, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC,
                4'hD, 4'hE, 4'hC, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 4'h0};
        return (opc <= 20) ? tab[opc] : 4'h0;
    endfunction

    function automatic ctrl_t model(logic r, logic [16:0] instr);
        ctrl_t       c;
        int unsigned opc;
        c   = '0;
        if (r) return c;
        opc  = int'(instr[16:12]);
        c.da = instr[11:9];
        c.aa = instr[8:6];
        c.ba = instr[5:3];
        c.fs = fs_of(opc);
        c.rw = ((opc >= 1) && (opc <= 15)) || (opc == 17);
        c.sh = (opc == 11 || opc == 12) ? instr[2:0] : 3'd0;
        c.mb = (opc == 13) || (opc == 14) || (opc == 19);
        c.cs = (opc == 14) || (opc == 19);
        c.md = (opc == 15) ? 2'b01 : (opc == 17) ? 2'b10 : 2'b00;
        c.mw = (opc == 16);
        c.oe = (opc == 18);
        c.bs = (opc == 19) ? 2'b01 : (opc == 20) ? 2'b10 : 2'b00;
        c.ps = (opc == 19);
        c.ma = (opc == 19);
        return c;
    endfunction

    task automatic issue(logic r, logic [16:0] instr);
        item_t it;
        @(negedge clk);
        rst            = r;
        Instruction_in = instr;
        it.exp   = model(r, instr);
        it.instr = instr;
        it.rst   = r;
        sb_q.push_back(it);
    endtask

    function automatic logic [16:0] mk(int unsigned opc, logic [2:0] op);
        logic [4:0] o;
        o = opc[4:0];
        return {o, 3'b101, 3'b111, 3'b001, op};
    endfunction

    // Monitor: the decoder presents a new word after every edge.
    initial begin : monitor
        item_t it;
        ctrl_t act;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() != 0) begin
                it  = sb_q.pop_front();
                act = '{da: DA, aa: AA, ba: BA, bs: BS, ps: PS, mw: MW, rw: RW,
                        ma: MA, mb: MB, md: MD, fs: FS, sh: SH, cs: CS, oe: OE};
                checks++;
                if (act !== it.exp) begin
                    failures++;
                    $display("FAIL decode rst=%0b opcode=%0d instr=%h actual=%h required=%h",
                             it.rst, it.instr[16:12], it.instr, act, it.exp);
                end
                checks++;
                if ((MW + RW + OE) > 1) begin
                    failures++;
                    $display("FAIL strobe_exclusive opcode=%0d actual MW/RW/OE=%0b%0b%0b required at most one",
                             it.instr[16:12], MW, RW, OE);
                end
            end
        end
    end

    initial begin : driver
        int unsigned wait_cycles;
        issue(1'b1, mk(3, 3'b000));
        for (int unsigned opc = 0; opc <= 20; opc++) begin
            issue(1'b0, mk(opc, 3'b000));
            if (opc == 10) issue(1'b1, mk(opc, 3'b000));
        end
        issue(1'b0, mk(12, 3'b011));
        issue(1'b0, mk(3, 3'b011));
        issue(1'b0, mk(11, 3'b110));
        issue(1'b0, mk(21, 3'b000));
        issue(1'b0, mk(31, 3'b111));
        for (int unsigned i = 0; i < 400; i++) begin
            logic [16:0] ins;
            logic        r;
            ins = 17'($urandom);
            if ($urandom_range(0, 3) != 0) ins[16:12] = 5'($urandom_range(0, 20));
            r = ($urandom_range(0, 19) == 0);
            issue(r, ins);
        end
        @(negedge clk);
        rst = 1'b0;
        driving_done = 1'b1;
        wait_cycles = 0;
        while (sb_q.size() != 0 && wait_cycles < 20) begin
            @(negedge clk);
            wait_cycles++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain actual pending=%0d required 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_decoder.md
Name: instruction_decoder

Overview:
- Decodes one 17-bit instruction word per cycle into datapath control signals for the 8-bit microprocessor:
  - register addresses
  - ALU function and shift amount
  - mux selects and memory/port strobes
  - branch controls
- Sits between the instruction register and the register file, ALU, memory and PC logic.
- Outputs are registered, giving one cycle of latency.

Parameters:
- None. All widths are fixed by the ISA.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  synchronous reset, active-high
- Instruction_in  in  17  fields:
  - [16:12] opcode
  - [11:9] DA
  - [8:6] AA
  - [5:3] BA
  - [2:0] OP (shift amount / 3-bit constant)
- DA  out  3  destination register address
- AA  out  3  A-bus source register address
- BA  out  3  B-bus source register address
- BS  out  2  branch select:
  - 00 PC+1
  - 01 conditional branch
  - 10 jump to R[AA]
  - 11 reserved
- PS  out  1  branch polarity; 1 = take branch when Z=1
- MW  out  1  memory write strobe
- RW  out  1  register file write enable
- MA  out  1  A-bus mux; 1 = PC, 0 = R[AA]
- MB  out  1  B-bus mux; 1 = constant OP, 0 = R[BA]
- MD  out  2  write-back select:
  - 00 ALU/shifter
  - 01 memory data
  - 10 input port
  - 11 reserved
- FS  out  4  ALU function select
- SH  out  3  shift amount
- CS  out  1  constant extension; 1 = sign-extend OP, 0 = zero-extend
- OE  out  1  output-port enable

Behaviour:
- All outputs are registered. Values decoded from Instruction_in at rising edge N appear after edge N; there is no combinational path from input to output.
- rst=1 at an edge forces all outputs to 0 (NOP state). rst has priority over decode. Reset mid-stream discards the instruction sampled on that edge.
- DA, AA and BA always copy fields [11:9], [8:6] and [5:3], for every opcode including NOP and illegal opcodes.
- SH = OP only for SHR and SHL; otherwise 000.
- FS codes:
  - 0000 A
  - 0001 A+1
  - 0010 A+B
  - 0101 A-B
  - 0110 A-1
  - 1000 AND
  - 1001 OR
  - 1010 XOR
  - 1011 NOT A
  - 1100 B
  - 1101 SHR
  - 1110 SHL
- Opcode map. Unlisted outputs are 0. Opcodes 1-15 and 17 set RW=1.
  - 0 NOP: all controls 0
  - 1 MOV: FS=0000
  - 2 INC: FS=0001
  - 3 ADD: FS=0010
  - 4 SUB: FS=0101
  - 5 DEC: FS=0110
  - 6 AND: FS=1000
  - 7 OR: FS=1001
  - 8 XOR: FS=1010
  - 9 NOT: FS=1011
  - 10 MOVB: FS=1100
  - 11 SHR: FS=1101, SH=OP
  - 12 SHL: FS=1110, SH=OP
  - 13 LDI: FS=1100, MB=1, CS=0
  - 14 ADI: FS=0010, MB=1, CS=1
  - 15 LD: MD=01
  - 16 ST: MW=1, RW=0
  - 17 IN: MD=10
  - 18 OUT: OE=1, RW=0
  - 19 BRZ: BS=01, PS=1, MA=1, MB=1, CS=1, FS=0010, RW=0
  - 20 JMP: BS=10, RW=0
- Opcodes 21-31 are illegal and decode exactly as NOP. The register fields are still passed through.
- MW, RW and OE are never asserted together in one decoded word.

Decomposition:
- Shared package (isa_pkg) holds:
  - opcode constants
  - FS codes
  - BS and MD encodings
  - instruction field bit positions
- One natural sub-module: id_decode_logic. It is a purely combinational opcode-to-control map.
- The top-level instruction_decoder wraps id_decode_logic with the output register and reset.

Test Plan:
- Reset: drive rst=1 with Instruction_in={5'd3,101,111,001,000} -> after the edge all outputs are 0, including DA/AA/BA.
- Sweep opcodes 0..20 with fields DA=101, AA=111, BA=001, OP=000, one per cycle -> after each edge:
  - DA=5, AA=7, BA=1
  - controls match the opcode map, e.g. opcode 3 gives FS=0010, RW=1, all others 0
- Shift amount: opcode 12 with OP=011 -> FS=1110, SH=011, RW=1. Then opcode 3 with OP=011 -> SH=000.
- Memory and port strobes:
  - opcode 16 -> MW=1, RW=0
  - opcode 15 -> MD=01, RW=1
  - opcode 18 -> OE=1, RW=0
- Branches:
  - opcode 19 -> BS=01, PS=1, MA=1, MB=1, CS=1, FS=0010, RW=0
  - opcode 20 -> BS=10, all else 0
- Illegal opcodes 21 and 31 -> all controls 0, DA/AA/BA still 5/7/1. Asserting rst mid-sweep -> all outputs 0 on that edge, and decoding resumes on the next edge.
